// File: rtl/owm_bit_engine.sv
// owm_bit_engine: bit-level 1-wire master timing engine.
// Accepts one command at a time (reset/presence, write0, write1, read), times the
// slot in prescaled ticks, drives the pull-low / strong pull-up enables of the
// selected line and samples that line at the sample point.
module owm_bit_engine #(
    parameter int OWN   = 2,
    parameter int SW    = 1,
    parameter int CDR_N = 24,
    parameter int CDR_O = 12
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [1:0]     cmd_code,
    input  logic           cmd_ovd,
    input  logic           cmd_pwr,
    input  logic [SW-1:0]  cmd_sel,
    output logic           rsp_valid,
    output logic           rsp_data,
    output logic [OWN-1:0] onewire_p,
    output logic [OWN-1:0] onewire_e,
    input  logic [OWN-1:0] onewire_i
);

    localparam int DIV_MAX = (CDR_N > CDR_O) ? CDR_N : CDR_O;
    localparam int PW      = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

    localparam logic [PW-1:0] PRE_LAST_N = PW'(CDR_N - 1);
    localparam logic [PW-1:0] PRE_LAST_O = PW'(CDR_O - 1);

    localparam logic [1:0] CODE_RESET = 2'd0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SLOT = 1'b1
    } state_t;

    state_t         state_reg;
    state_t         state_next;

    logic [1:0]     code_reg;
    logic           ovd_reg;
    logic           pwr_reg;
    logic [SW-1:0]  sel_reg;
    logic [PW-1:0]  pre_reg;
    logic [9:0]     cnt_reg;
    logic           smp_reg;
    logic           rsp_valid_reg;
    logic           rsp_data_reg;
    logic [OWN-1:0] e_reg;
    logic [OWN-1:0] p_reg;

    // One-hot line decodes; an out-of-range select yields an all-zero mask,
    // so nothing is driven and the sample falls back to an idle-high bus.
    logic [OWN-1:0] cmd_hit;
    logic [OWN-1:0] sel_hit;

    logic           accept;
    logic           tick;
    logic [9:0]     cnt_inc;
    logic [9:0]     t_low;
    logic [9:0]     t_smp;
    logic [9:0]     t_end;
    logic           hit_low;
    logic           hit_smp;
    logic           hit_end;
    logic           line_smp;

    genvar gi;
    generate
        for (gi = 0; gi < OWN; gi++) begin : g_line
            assign cmd_hit[gi] = (cmd_sel == SW'(gi));
            assign sel_hit[gi] = (sel_reg == SW'(gi));
        end
    endgenerate

    assign cmd_ready = (state_reg == ST_IDLE);
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign onewire_e = e_reg;
    assign onewire_p = p_reg;

    // Slot timing (low, sample, end) in ticks for the latched command.
    always_comb begin
        t_low = 10'd0;
        t_smp = 10'd0;
        t_end = 10'd0;
        case ({ovd_reg, code_reg})
            3'b0_00: begin t_low = 10'd480; t_smp = 10'd550; t_end = 10'd960; end
            3'b0_01: begin t_low = 10'd60;  t_smp = 10'd15;  t_end = 10'd70;  end
            3'b0_10,
            3'b0_11: begin t_low = 10'd6;   t_smp = 10'd15;  t_end = 10'd70;  end
            3'b1_00: begin t_low = 10'd96;  t_smp = 10'd112; t_end = 10'd192; end
            3'b1_01: begin t_low = 10'd15;  t_smp = 10'd4;   t_end = 10'd20;  end
            default: begin t_low = 10'd2;   t_smp = 10'd4;   t_end = 10'd20;  end
        endcase
    end

    // Tick generation and slot event decode; events fire on the tick that
    // moves cnt onto the programmed value.
    always_comb begin
        accept   = (state_reg == ST_IDLE) && cmd_valid;
        tick     = (state_reg == ST_SLOT) &&
                   (pre_reg == (ovd_reg ? PRE_LAST_O : PRE_LAST_N));
        cnt_inc  = cnt_reg + 10'd1;
        hit_low  = tick && (cnt_inc == t_low);
        hit_smp  = tick && (cnt_inc == t_smp);
        hit_end  = tick && (cnt_inc == t_end);
        line_smp = (|sel_hit) ? (|(onewire_i & sel_hit)) : 1'b1;
    end

    // Next-state logic: IDLE until a command is accepted, SLOT until the end tick.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept)  state_next = ST_SLOT;
            ST_SLOT: if (hit_end) state_next = ST_IDLE;
            default:              state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath: command latch, prescaler/tick counter, line drive, sample, response.
    always_ff @(posedge clk) begin
        if (rst) begin
            code_reg      <= 2'd0;
            ovd_reg       <= 1'b0;
            pwr_reg       <= 1'b0;
            sel_reg       <= '0;
            pre_reg       <= '0;
            cnt_reg       <= 10'd0;
            smp_reg       <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= 1'b0;
            e_reg         <= '0;
            p_reg         <= '0;
        end else begin
            rsp_valid_reg <= 1'b0;
            if (accept) begin
                code_reg <= cmd_code;
                ovd_reg  <= cmd_ovd;
                pwr_reg  <= cmd_pwr;
                sel_reg  <= cmd_sel;
                pre_reg  <= '0;
                cnt_reg  <= 10'd0;
                e_reg    <= cmd_hit;
                p_reg    <= '0;
            end else if (state_reg == ST_SLOT) begin
                if (tick) begin
                    pre_reg <= '0;
                    cnt_reg <= cnt_inc;
                end else begin
                    pre_reg <= pre_reg + PW'(1);
                end
                if (hit_low) begin
                    e_reg <= '0;
                end
                if (hit_smp) begin
                    smp_reg <= line_smp;
                end
                // The sample point always precedes the end tick, so smp_reg is settled here.
                if (hit_end) begin
                    rsp_valid_reg <= 1'b1;
                    rsp_data_reg  <= (code_reg == CODE_RESET) ? ~smp_reg : smp_reg;
                    p_reg         <= pwr_reg ? sel_hit : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_owm_bit_engine.sv
// tb_owm_bit_engine: self-checking bench for the 1-wire bit engine.
// Expected timing and results come from the slot tables and a tick-level bus model.
module tb_owm_bit_engine;

    localparam int OWN   = 3;
    localparam int SW    = 2;
    localparam int CDR_N = 24;
    localparam int CDR_O = 12;

    logic           clk = 1'b0;
    logic           rst;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [1:0]     cmd_code;
    logic           cmd_ovd;
    logic           cmd_pwr;
    logic [SW-1:0]  cmd_sel;
    logic           rsp_valid;
    logic           rsp_data;
    logic [OWN-1:0] onewire_p;
    logic [OWN-1:0] onewire_e;
    logic [OWN-1:0] onewire_i;
    logic [OWN-1:0] slave_low;

    int n_checks = 0;
    int n_fail   = 0;
    int rsp_seen = 0;
    int rsp_exp  = 0;

    owm_bit_engine #(
        .OWN   (OWN),
        .SW    (SW),
        .CDR_N (CDR_N),
        .CDR_O (CDR_O)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_code  (cmd_code),
        .cmd_ovd   (cmd_ovd),
        .cmd_pwr   (cmd_pwr),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .onewire_p (onewire_p),
        .onewire_e (onewire_e),
        .onewire_i (onewire_i)
    );

    // Wired-AND bus: low when the master pulls it or the slave pulls it.
    assign onewire_i = ~(onewire_e | slave_low);

    always #5 clk = ~clk;

    // Count every response pulse seen on the port.
    always @(negedge clk) begin
        if (rsp_valid) rsp_seen++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Slot table: which 0=low, 1=sample, 2=end; kind 0=reset, 1=write0, 2=write1/read.
    function automatic int tval(input int which, input int code, input bit ovd);
        int tab [2][3][3];
        int kind;
        tab = '{'{'{480, 550, 960}, '{60, 15, 70}, '{6, 15, 70}},
                '{'{96, 112, 192},  '{15, 4, 20},  '{2, 4, 20}}};
        kind = (code >= 2) ? 2 : code;
        return tab[ovd][kind][which];
    endfunction

    // Issue one command (or, with pre_acc, follow one already presented) and check
    // the whole slot. The slave pulls the selected line low for ticks [ps, pe).
    // With hold, cmd_valid stays high and the fields are scrambled during the slot,
    // then restored so the same command is accepted again in the rsp_valid cycle.
    task automatic run_cmd(input logic [1:0] code, input bit ovd, input bit pwr,
                           input logic [SW-1:0] sel, input int ps, input int pe,
                           input bit pre_acc, input bit hold, input string tag);
        int div, tl, ts, te, k, lat, e_cnt, bad_other, overlap, busy_ready;
        bit got_rsp, first_e, in_range, exp_smp, exp_data;
        logic [OWN-1:0] mask;
        div = ovd ? CDR_O : CDR_N;
        tl  = tval(0, code, ovd);
        ts  = tval(1, code, ovd);
        te  = tval(2, code, ovd);
        in_range = (int'(sel) < OWN);
        for (int i = 0; i < OWN; i++) mask[i] = (i == int'(sel));
        check_eq({tag, ".ready"}, cmd_ready, 1);
        if (!pre_acc) begin
            cmd_valid = 1'b1;
            cmd_code  = code;
            cmd_ovd   = ovd;
            cmd_pwr   = pwr;
            cmd_sel   = sel;
        end
        @(posedge clk);
        rsp_exp++;
        k = 0; lat = 0; e_cnt = 0; bad_other = 0; overlap = 0; busy_ready = 0;
        got_rsp = 1'b0; first_e = 1'b0;
        while (!got_rsp && k <= te * div + 4) begin
            @(negedge clk);
            if (k == 0) begin
                if (!hold) cmd_valid = 1'b0;
                first_e = ((onewire_e & mask) != '0);
                check_eq({tag, ".p_clr"}, onewire_p, 0);
            end
            if ((onewire_e & mask) != '0)  e_cnt++;
            if ((onewire_e & ~mask) != '0) bad_other++;
            if ((onewire_e & onewire_p) != '0) overlap++;
            if (rsp_valid) begin
                got_rsp = 1'b1;
                lat = k;
            end else if (cmd_ready) begin
                busy_ready++;
            end
            slave_low = ((k + 1 >= ps * div) && (k + 1 < pe * div)) ? mask : '0;
            if (hold) begin
                if (k + 1 >= te * div) begin
                    cmd_code = code; cmd_ovd = ovd; cmd_pwr = pwr; cmd_sel = sel;
                end else begin
                    cmd_code = 2'($urandom); cmd_ovd = 1'($urandom);
                    cmd_pwr  = 1'($urandom); cmd_sel = SW'($urandom);
                end
            end
            if (!got_rsp) k++;
        end
        slave_low = '0;
        exp_smp  = in_range ? !((ts <= tl) || ((ts >= ps) && (ts < pe))) : 1'b1;
        exp_data = (code == 2'd0) ? !exp_smp : exp_smp;
        check_eq({tag, ".rsp_seen"}, got_rsp, 1);
        check_eq({tag, ".latency"}, lat + 1, te * div + 1);
        check_eq({tag, ".first_e"}, first_e, in_range);
        check_eq({tag, ".low_time"}, e_cnt, in_range ? tl * div : 0);
        check_eq({tag, ".other_e"}, bad_other, 0);
        check_eq({tag, ".p_and_e"}, overlap, 0);
        check_eq({tag, ".busy_ready"}, busy_ready, 0);
        check_eq({tag, ".rsp_data"}, rsp_data, exp_data);
        check_eq({tag, ".p_rsp"}, onewire_p, pwr ? mask : '0);
        $display("txn %s code=%0d ovd=%0d pwr=%0d sel=%0d lat=%0d low=%0d data=%0d",
                 tag, code, ovd, pwr, sel, lat + 1, e_cnt, rsp_data);
        if (!hold) begin
            @(negedge clk);
            check_eq({tag, ".pulse"}, rsp_valid, 0);
            check_eq({tag, ".data_hold"}, rsp_data, exp_data);
            check_eq({tag, ".p_hold"}, onewire_p, pwr ? mask : '0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_code  = 2'd0;
        cmd_ovd   = 1'b0;
        cmd_pwr   = 1'b0;
        cmd_sel   = '0;
        slave_low = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset.ready", cmd_ready, 1);
        check_eq("reset.rsp_valid", rsp_valid, 0);
        check_eq("reset.rsp_data", rsp_data, 0);
        check_eq("reset.e", onewire_e, 0);
        check_eq("reset.p", onewire_p, 0);
        rst = 1'b0;
        @(negedge clk);

        // Presence pulse, then empty bus.
        run_cmd(2'd0, 1'b0, 1'b0, 2'd0, 500, 600, 1'b0, 1'b0, "std_reset_pd");
        run_cmd(2'd0, 1'b0, 1'b0, 2'd0, 0, 0, 1'b0, 1'b0, "std_reset_nopd");
        run_cmd(2'd1, 1'b0, 1'b0, 2'd1, 0, 0, 1'b0, 1'b0, "std_write0");
        run_cmd(2'd3, 1'b1, 1'b0, 2'd0, 0, 6, 1'b0, 1'b0, "ovd_read_low");
        run_cmd(2'd3, 1'b1, 1'b0, 2'd0, 0, 0, 1'b0, 1'b0, "ovd_read_high");

        // Strong pull-up persists through idle until the next accept.
        run_cmd(2'd2, 1'b0, 1'b1, 2'd2, 0, 0, 1'b0, 1'b0, "w1_pwr");
        repeat (5) @(negedge clk);
        check_eq("w1_pwr.p_idle", onewire_p, 3'b100);
        run_cmd(2'd2, 1'b0, 1'b1, 2'd1, 0, 71, 1'b0, 1'b0, "w1_collide");

        // Reset clears a held strong pull-up.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_idle.p", onewire_p, 0);
        check_eq("rst_idle.rsp_data", rsp_data, 0);
        @(negedge clk);

        // Reset in the middle of a reset-low phase.
        cmd_valid = 1'b1; cmd_code = 2'd0; cmd_ovd = 1'b0; cmd_pwr = 1'b0; cmd_sel = 2'd0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (200 * CDR_N) @(negedge clk);
        check_eq("abort.mid_e", onewire_e, 3'b001);
        check_eq("abort.mid_ready", cmd_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort.e", onewire_e, 0);
        check_eq("abort.p", onewire_p, 0);
        check_eq("abort.ready", cmd_ready, 1);
        check_eq("abort.rsp_valid", rsp_valid, 0);
        repeat (4) @(negedge clk);
        run_cmd(2'd1, 1'b0, 1'b0, 2'd0, 0, 0, 1'b0, 1'b0, "after_abort");

        // Held cmd_valid: one rsp per accept, back-to-back accept in the rsp cycle.
        run_cmd(2'd2, 1'b1, 1'b0, 2'd0, 0, 0, 1'b0, 1'b1, "b2b_first");
        run_cmd(2'd2, 1'b1, 1'b0, 2'd0, 0, 0, 1'b1, 1'b0, "b2b_second");

        // Select beyond the implemented lines.
        run_cmd(2'd3, 1'b1, 1'b0, 2'd3, 0, 0, 1'b0, 1'b0, "oor_read");
        run_cmd(2'd0, 1'b1, 1'b1, 2'd3, 0, 0, 1'b0, 1'b0, "oor_reset");

        // Randomised commands and slave windows (standard reset kept out for run time).
        for (int i = 0; i < 10; i++) begin
            logic [1:0]    code;
            logic [SW-1:0] sel;
            bit            ovd, pwr;
            int            te, ps, pe;
            code = 2'($urandom_range(0, 3));
            ovd  = 1'($urandom_range(0, 1));
            if (code == 2'd0) ovd = 1'b1;
            pwr  = 1'($urandom_range(0, 1));
            sel  = SW'($urandom_range(0, 3));
            te   = tval(2, code, ovd);
            ps   = $urandom_range(0, te);
            pe   = $urandom_range(ps, te + 1);
            run_cmd(code, ovd, pwr, sel, ps, pe, 1'b0, 1'b0, $sformatf("rnd%0d", i));
        end

        repeat (3) @(negedge clk);
        check_eq("rsp_count", rsp_seen, rsp_exp);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
